// File: rtl/kbd_pkg.sv
// Shared types and constants for the 3x4 keypad scanner and debouncer.
package kbd_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRESS_DEB,
    HELD,
    REL_DEB
  } kbd_state_t;

  localparam logic [3:0] NO_KEY = 4'hF;
  localparam int         ROWS   = 4;

endpackage

// File: rtl/kbd_row_decode.sv
// Combinational decode of one row sample into a digit, a hit flag, or an invalid flag.
module kbd_row_decode
  import kbd_pkg::*;
(
  input  logic [1:0] sel,
  input  logic [2:0] column,
  output logic [3:0] code,
  output logic       hit,
  output logic       invalid
);

  logic [3:0] pos;
  logic       single;

  always_comb begin
    pos     = 4'd0;
    single  = 1'b0;
    code    = NO_KEY;
    hit     = 1'b0;
    invalid = 1'b0;

    case (column)
      3'b011:  begin pos = 4'd0; single = 1'b1; end
      3'b101:  begin pos = 4'd1; single = 1'b1; end
      3'b110:  begin pos = 4'd2; single = 1'b1; end
      3'b111:  single = 1'b0;
      default: invalid = 1'b1;
    endcase

    // The bottom row carries only the centre key (digit 0).
    if (sel == 2'd3) begin
      if (column == 3'b101) begin
        code = 4'd0;
        hit  = 1'b1;
      end else if (column != 3'b111) begin
        invalid = 1'b1;
      end
    end else if (single) begin
      code = ({2'b00, sel} * 4'd3) + pos + 4'd1;
      hit  = 1'b1;
    end
  end

endmodule

// File: rtl/key_scan_debounce.sv
// Row-scanning keypad controller with frame-based press/release debouncing.
module key_scan_debounce
  import kbd_pkg::*;
#(
  parameter int SCAN_DIV  = 8192,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] column,
  output logic [2:0] sel,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [1:0]    LAST_ROW = 2'(ROWS - 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_DONE = CW'(DEB_SCANS);

  logic [2:0]    sync1, sync2;
  logic [PW-1:0] presc;
  logic [1:0]    row;
  logic          tick;
  logic          frame_done;

  logic [3:0]    row_code;
  logic          row_hit;
  logic          row_invalid;

  logic [1:0]    acc_hits;
  logic [3:0]    acc_code;
  logic          acc_bad;

  logic [1:0]    frame_hits;
  logic [3:0]    frame_code;
  logic          frame_key;

  kbd_state_t    state, state_next;
  logic [CW-1:0] cnt, cnt_next, cnt_inc;
  logic [3:0]    cand, cand_next;
  logic [3:0]    code_next;
  logic          down_next;
  logic          valid_next;

  assign sel        = {1'b0, row};
  assign tick       = (presc == PRE_MAX);
  assign frame_done = tick && (row == LAST_ROW);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      presc <= '0;
      row   <= 2'd0;
    end else begin
      sync1 <= column;
      sync2 <= sync1;
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) row <= row + 2'd1;
    end
  end

  kbd_row_decode u_row_decode (
    .sel     (row),
    .column  (sync2),
    .code    (row_code),
    .hit     (row_hit),
    .invalid (row_invalid)
  );

  // Hit count saturates at 2: anything beyond "exactly one" is a NONE frame.
  always_comb begin
    frame_hits = acc_hits;
    frame_code = acc_code;
    if (row_hit) begin
      frame_hits = (acc_hits == 2'd0) ? 2'd1 : 2'd2;
      frame_code = row_code;
    end
    frame_key = !(acc_bad || row_invalid) && (frame_hits == 2'd1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_hits <= 2'd0;
      acc_code <= NO_KEY;
      acc_bad  <= 1'b0;
    end else if (frame_done) begin
      acc_hits <= 2'd0;
      acc_code <= NO_KEY;
      acc_bad  <= 1'b0;
    end else if (tick) begin
      acc_hits <= frame_hits;
      acc_code <= frame_code;
      acc_bad  <= acc_bad || row_invalid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= NO_KEY;
      key_code  <= NO_KEY;
      key_down  <= 1'b0;
      key_valid <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      cand      <= cand_next;
      key_code  <= code_next;
      key_down  <= down_next;
      key_valid <= valid_next;
    end
  end

  assign cnt_inc = cnt + 1'b1;

  // Transitions are taken only on the edge that closes a frame.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    cand_next  = cand;
    code_next  = key_code;
    down_next  = key_down;
    valid_next = 1'b0;

    if (frame_done) begin
      case (state)
        IDLE: begin
          if (frame_key) begin
            cand_next  = frame_code;
            cnt_next   = CW'(1);
            state_next = PRESS_DEB;
          end
        end
        PRESS_DEB: begin
          if (!frame_key) begin
            cnt_next   = '0;
            state_next = IDLE;
          end else if (frame_code != cand) begin
            cand_next = frame_code;
            cnt_next  = CW'(1);
          end else if (cnt_inc == CNT_DONE) begin
            cnt_next   = cnt_inc;
            code_next  = cand;
            down_next  = 1'b1;
            valid_next = 1'b1;
            state_next = HELD;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        HELD: begin
          if (!frame_key) begin
            cnt_next   = CW'(1);
            state_next = REL_DEB;
          end
        end
        REL_DEB: begin
          if (frame_key) begin
            state_next = HELD;
          end else if (cnt_inc == CNT_DONE) begin
            cnt_next   = '0;
            down_next  = 1'b0;
            state_next = IDLE;
          end else begin
            cnt_next = cnt_inc;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_key_scan_debounce.sv
// Scoreboard bench: a keypad model drives columns from sel; a monitor checks each strobe.
module tb_key_scan_debounce;

  logic       clk;
  logic       reset;
  logic [2:0] column;
  logic [2:0] sel;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  logic [9:0] pressed;
  logic       bad_row2;

  int         checks;
  int         errors;
  int         strobes;
  logic [3:0] exp_q[$];

  key_scan_debounce #(
    .SCAN_DIV  (4),
    .DEB_SCANS (3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .column    (column),
    .sel       (sel),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_down  (key_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Active-low column pattern seen on the given row for the set of pressed keys.
  function automatic logic [2:0] col_for(logic [9:0] keys, logic [1:0] row, logic bad);
    logic [2:0] c;
    int r, p;
    c = 3'b111;
    for (int k = 0; k < 10; k++) begin
      if (keys[k]) begin
        if (k == 0) begin r = 3; p = 1; end
        else begin r = (k - 1) / 3; p = (k - 1) % 3; end
        if (r == int'(row)) c[2-p] = 1'b0;
      end
    end
    if (bad && row == 2'd2) c = 3'b001;
    return c;
  endfunction

  assign column = col_for(pressed, sel[1:0], bad_row2);

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic next_frame();
    logic [2:0] prev;
    logic       found;
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      prev = sel;
      @(posedge clk);
      #1;
      if (prev == 3'd3 && sel == 3'd0) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("[TB] FAIL frame_boundary actual=timeout expected=boundary");
    end
  endtask

  task automatic frames(input int n);
    for (int i = 0; i < n; i++) next_frame();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      strobes++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL strobe actual=%h expected=none", key_code);
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if (key_code !== e || key_down !== 1'b1) begin
          errors++;
          $display("[TB] FAIL strobe_code actual=%h/%b expected=%h/1", key_code, key_down, e);
        end
      end
    end
  end

  initial begin
    int s0;
    checks   = 0;
    errors   = 0;
    strobes  = 0;
    pressed  = '0;
    bad_row2 = 1'b0;
    reset    = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_sel", {1'b0, sel}, 4'd0);
    check("rst_code", key_code, 4'hF);
    check("rst_valid", {3'b0, key_valid}, 4'd0);
    check("rst_down", {3'b0, key_down}, 4'd0);
    reset = 1'b0;
    next_frame();

    // Short press of 1: never accepted.
    pressed = 10'b1 << 1;
    frames(2);
    pressed = '0;
    frames(3);
    check_int("short_no_strobe", strobes, 0);
    check("short_code", key_code, 4'hF);

    // Key 5 accepted exactly at the end of the third frame.
    s0 = strobes;
    pressed = 10'b1 << 5;
    exp_q.push_back(4'd5);
    frames(2);
    check_int("k5_latency", strobes, s0);
    frames(1);
    check_int("k5_strobe", strobes, s0 + 1);
    check("k5_code", key_code, 4'd5);
    check("k5_down", {3'b0, key_down}, 4'd1);
    pressed = '0;
    frames(2);
    check("k5_rel_pending", {3'b0, key_down}, 4'd1);
    frames(1);
    check("k5_released", {3'b0, key_down}, 4'd0);

    // Invalid row2 pattern masks a genuine key 1.
    s0 = strobes;
    pressed  = 10'b1 << 1;
    bad_row2 = 1'b1;
    frames(4);
    check_int("invalid_no_strobe", strobes, s0);
    check("invalid_down", {3'b0, key_down}, 4'd0);
    pressed  = '0;
    bad_row2 = 1'b0;
    frames(1);

    // Key 8: a one-frame release glitch does not re-strobe.
    s0 = strobes;
    pressed = 10'b1 << 8;
    exp_q.push_back(4'd8);
    frames(3);
    pressed = '0;
    frames(1);
    pressed = 10'b1 << 8;
    frames(1);
    check("k8_glitch_down", {3'b0, key_down}, 4'd1);
    pressed = '0;
    frames(2);
    check("k8_rel_pending", {3'b0, key_down}, 4'd1);
    frames(1);
    check("k8_released", {3'b0, key_down}, 4'd0);
    check_int("k8_single_strobe", strobes, s0 + 1);

    // Keys 3 and 0 together form NONE frames; then 2 held, rolled to 9.
    s0 = strobes;
    pressed = (10'b1 << 3) | 10'b1;
    frames(4);
    check_int("multi_no_strobe", strobes, s0);
    pressed = '0;
    frames(1);
    pressed = 10'b1 << 2;
    exp_q.push_back(4'd2);
    frames(3);
    pressed = 10'b1 << 9;
    frames(3);
    check_int("rollover_strobes", strobes, s0 + 1);
    check("rollover_code", key_code, 4'd2);
    check("rollover_down", {3'b0, key_down}, 4'd1);
    pressed = '0;
    frames(3);
    check("k2_released", {3'b0, key_down}, 4'd0);

    // Reset in the middle of debouncing key 4.
    s0 = strobes;
    pressed = 10'b1 << 4;
    frames(2);
    repeat (6) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_sel", {1'b0, sel}, 4'd0);
    check("mid_rst_code", key_code, 4'hF);
    check("mid_rst_valid", {3'b0, key_valid}, 4'd0);
    check("mid_rst_down", {3'b0, key_down}, 4'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.push_back(4'd4);
    frames(2);
    check_int("post_rst_latency", strobes, s0);
    frames(1);
    check_int("post_rst_strobe", strobes, s0 + 1);
    check("post_rst_code", key_code, 4'd4);
    pressed = '0;
    frames(3);
    check("post_rst_released", {3'b0, key_down}, 4'd0);

    check_int("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
